// File: rtl/ttl_serializer_sync_if.sv
// Load handshake and serial line bundle for ttl_serializer_sync.
// master drives cen and the load side; slave is the serializer.
interface ttl_serializer_sync_if #(
  parameter int WIDTH = 4
) ();
  logic             cen;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             ser_out;
  logic             shift_en;
  logic             busy;
  logic             frame_done;

  modport master (
    output cen, load_valid, load_data,
    input  load_ready, ser_out, shift_en, busy, frame_done
  );

  modport slave (
    input  cen, load_valid, load_data,
    output load_ready, ser_out, shift_en, busy, frame_done
  );
endinterface

// File: rtl/ttl_serializer_sync.sv
// Parallel-in serial-out sender for a 74194-style receiver, cen-edge driven.
// Define TTL_SERIALIZER_PARITY_EN to append an even-parity bit to each frame.
module ttl_serializer_sync #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  ttl_serializer_sync_if.slave bus
);

`ifdef TTL_SERIALIZER_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_SHIFT,
    S_TAIL
  } state_t;

  state_t          r_state, w_state_n;
  logic            r_last_cen;
  logic [FLEN-1:0] r_shreg, w_shreg_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic            r_ser, w_ser_n;
  logic            r_sen, w_sen_n;
  logic            r_done, w_done_n;

  logic            w_rise, w_fall, w_head;
  logic [FLEN-1:0] w_load, w_shifted;

  assign w_rise = bus.cen & ~r_last_cen;
  assign w_fall = ~bus.cen & r_last_cen;

  // Register is loaded so the first bit to send sits at the output end.
`ifdef TTL_SERIALIZER_PARITY_EN
  logic w_par;
  assign w_par  = ^bus.load_data;
  assign w_load = MSB_FIRST ? {bus.load_data, w_par}
                            : {w_par, bus.load_data};
`else
  assign w_load = bus.load_data;
`endif

  assign w_head    = MSB_FIRST ? r_shreg[FLEN-1] : r_shreg[0];
  assign w_shifted = MSB_FIRST ? {r_shreg[FLEN-2:0], 1'b0}
                               : {1'b0, r_shreg[FLEN-1:1]};

  always_comb begin
    w_state_n = r_state;
    w_shreg_n = r_shreg;
    w_cnt_n   = r_cnt;
    w_ser_n   = r_ser;
    w_sen_n   = r_sen;
    w_done_n  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.load_valid) begin
          w_shreg_n = w_load;
          w_cnt_n   = '0;
          w_state_n = S_ARM;
        end
      end
      S_ARM: begin
        if (w_fall) begin
          w_ser_n   = w_head;
          w_shreg_n = w_shifted;
          w_sen_n   = 1'b1;
          w_state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_rise) begin
          w_cnt_n = r_cnt + 1'b1;
          if (w_cnt_n == CW'(FLEN))
            w_state_n = S_TAIL;
        end else if (w_fall) begin
          w_ser_n   = w_head;
          w_shreg_n = w_shifted;
        end
      end
      S_TAIL: begin
        // Drop shift_en before the receiver's next rising edge so it holds.
        if (w_fall) begin
          w_sen_n   = 1'b0;
          w_ser_n   = 1'b0;
          w_done_n  = 1'b1;
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last_cen <= 1'b1;
      r_shreg    <= '0;
      r_cnt      <= '0;
      r_ser      <= 1'b0;
      r_sen      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_last_cen <= bus.cen;
      r_shreg    <= w_shreg_n;
      r_cnt      <= w_cnt_n;
      r_ser      <= w_ser_n;
      r_sen      <= w_sen_n;
      r_done     <= w_done_n;
    end
  end

  assign bus.load_ready = (r_state == S_IDLE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.ser_out    = r_ser;
  assign bus.shift_en   = r_sen;
  assign bus.frame_done = r_done;

endmodule

// File: tb/tb_ttl_serializer_sync.sv
// Bench for ttl_serializer_sync: MSB-first and LSB-first instances side by side,
// checked against a frame-level model plus a 74194 shift-right receiver.
module tb_ttl_serializer_sync;

`ifdef TTL_SERIALIZER_PARITY_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cen;
  logic       lv;
  logic [3:0] ld;

  always #5 clk = ~clk;

  ttl_serializer_sync_if #(.WIDTH(4)) bus0 ();
  ttl_serializer_sync_if #(.WIDTH(4)) bus1 ();

  assign bus0.cen        = cen;
  assign bus0.load_valid = lv;
  assign bus0.load_data  = ld;
  assign bus1.cen        = cen;
  assign bus1.load_valid = lv;
  assign bus1.load_data  = ld;

  ttl_serializer_sync #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  ttl_serializer_sync #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  logic [1:0] d_ser, d_sen, d_busy, d_rdy, d_done;
  assign d_ser  = {bus1.ser_out,    bus0.ser_out};
  assign d_sen  = {bus1.shift_en,   bus0.shift_en};
  assign d_busy = {bus1.busy,       bus0.busy};
  assign d_rdy  = {bus1.load_ready, bus0.load_ready};
  assign d_done = {bus1.frame_done, bus0.frame_done};

  int errors = 0;
  int checks = 0;

  // Frame-level model: k counts cen falling edges since the word was taken.
  // Bit i of the frame is on the line after fall i+1; fall FLEN+1 ends it.
  bit              m_act  = 1'b0;
  bit              m_done = 1'b0;
  bit              m_lc   = 1'b1;
  int              m_k    = 0;
  logic [3:0]      m_word = '0;
  logic            m_par  = 1'b0;
  logic [FLEN-1:0] rx [2];
  int              rx_cnt [2];

  function automatic logic fbit(int d, logic [3:0] w, logic p, int i);
    if (i >= 4) return p;
    return (d == 0) ? w[3-i] : w[i];
  endfunction

  function automatic logic [FLEN-1:0] exp_rx(int d);
    logic [FLEN-1:0] r;
    r = '0;
    for (int i = 0; i < FLEN; i++)
      r[FLEN-1-i] = fbit(d, m_word, m_par, i);
    return r;
  endfunction

  // Compare current outputs, then advance the model to the next posedge.
  always @(negedge clk) begin
    logic       esen, eser, rise, fall;
    logic [4:0] got, want;
    if (rst) begin
      m_act  = 1'b0;
      m_done = 1'b0;
      m_lc   = 1'b1;
      m_k    = 0;
    end
    esen = m_act && (m_k >= 1) && (m_k <= FLEN);
    for (int d = 0; d < 2; d++) begin
      eser = esen ? fbit(d, m_word, m_par, m_k - 1) : 1'b0;
      want = {m_act, !m_act, esen, eser, m_done};
      got  = {d_busy[d], d_rdy[d], d_sen[d], d_ser[d], d_done[d]};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL outputs dut%0d t=%0t busy/rdy/sen/ser/done got=%b want=%b",
                 d, $time, got, want);
      end
      if (m_done) begin
        checks++;
        if (rx_cnt[d] != FLEN || rx[d] !== exp_rx(d)) begin
          errors++;
          $display("FAIL frame dut%0d t=%0t rx=%b shifts=%0d want rx=%b shifts=%0d",
                   d, $time, rx[d], rx_cnt[d], exp_rx(d), FLEN);
        end
      end
    end
    if (!rst) begin
      rise   = cen && !m_lc;
      fall   = !cen && m_lc;
      m_lc   = cen;
      m_done = 1'b0;
      for (int d = 0; d < 2; d++)
        if (rise && d_sen[d]) begin
          rx[d] = {rx[d][FLEN-2:0], d_ser[d]};
          rx_cnt[d]++;
        end
      if (!m_act) begin
        if (lv) begin
          m_act     = 1'b1;
          m_k       = 0;
          m_word    = ld;
          m_par     = ^ld;
          rx_cnt[0] = 0;
          rx_cnt[1] = 0;
        end
      end else if (fall) begin
        m_k++;
        if (m_k == FLEN + 1) begin
          m_act  = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(string name, logic [7:0] got, logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  task automatic load(logic [3:0] w);
    lv = 1'b1;
    ld = w;
    cyc();
    lv = 1'b0;
  endtask

  // Toggle cen every half clks until the MSB instance goes idle.
  task automatic run_frame(int half);
    int c;
    c = 0;
    while (1) begin
      cyc();
      c++;
      if (c % half == 0) cen = ~cen;
      if (!d_busy[0] || c > 2000) break;
    end
    checks++;
    if (d_busy[0]) begin
      errors++;
      $display("FAIL frame_timeout busy=%b want 0", d_busy[0]);
    end
  endtask

`ifdef TTL_SERIALIZER_PARITY_EN
  localparam logic [7:0] E_B_M = 8'b10111, E_B_L = 8'b11011;
  localparam logic [7:0] E_5_M = 8'b01010, E_5_L = 8'b10100;
  localparam logic [7:0] E_F_M = 8'b11110, E_F_L = 8'b11110;
  localparam logic [7:0] E_A_M = 8'b10100, E_A_L = 8'b01010;
  localparam logic [7:0] E_9_M = 8'b10010, E_9_L = 8'b10010;
`else
  localparam logic [7:0] E_B_M = 8'b1011, E_B_L = 8'b1101;
  localparam logic [7:0] E_5_M = 8'b0101, E_5_L = 8'b1010;
  localparam logic [7:0] E_F_M = 8'b1111, E_F_L = 8'b1111;
  localparam logic [7:0] E_A_M = 8'b1010, E_A_L = 8'b0101;
  localparam logic [7:0] E_9_M = 8'b1001, E_9_L = 8'b1001;
`endif

  initial begin
    rst = 1'b1;
    cen = 1'b1;
    lv  = 1'b0;
    ld  = '0;
    rx[0] = '0;
    rx[1] = '0;
    rx_cnt[0] = 0;
    rx_cnt[1] = 0;
    repeat (3) cyc();
    chk("reset_outs", {d_ser, d_sen, d_busy, d_done}, 8'h00);
    chk("reset_ready", {6'd0, d_rdy}, 8'h03);
    rst = 1'b0;
    cyc();

    load(4'b1011);
    run_frame(4);
    chk("msb_1011", 8'(rx[0]), E_B_M);
    chk("lsb_1011", 8'(rx[1]), E_B_L);
    chk("ready_back", {6'd0, d_rdy}, 8'h03);
    repeat (16) begin
      cyc();
      if ($time % 4 == 0) cen = ~cen;
    end
    repeat (4) begin
      repeat (4) cyc();
      cen = ~cen;
    end
    chk("lsb_hold", 8'(rx[1]), E_B_L);

    lv = 1'b1;
    ld = 4'h5;
    cyc();
    ld = 4'hF;
    run_frame(4);
    chk("busy_word_5", 8'(rx[0]), E_5_M);
    chk("busy_word_5l", 8'(rx[1]), E_5_L);
    cyc();
    lv = 1'b0;
    chk("f_accepted", {6'd0, d_busy}, 8'h03);
    run_frame(4);
    chk("second_f", 8'(rx[0]), E_F_M);
    chk("second_fl", 8'(rx[1]), E_F_L);

    load(4'h3);
    repeat (4) begin
      repeat (4) cyc();
      cen = ~cen;
    end
    repeat (2) cyc();
    rst = 1'b1;
    #1;
    chk("midrst_outs", {d_ser, d_sen, d_busy, d_done}, 8'h00);
    repeat (2) cyc();
    rst = 1'b0;
    cen = 1'b1;
    cyc();
    load(4'hA);
    run_frame(4);
    chk("after_rst_a", 8'(rx[0]), E_A_M);
    chk("after_rst_al", 8'(rx[1]), E_A_L);

    cen = 1'b0;
    repeat (3) cyc();
    load(4'b1001);
    repeat (100) cyc();
    chk("stall_busy", {6'd0, d_busy}, 8'h03);
    chk("stall_sen", {6'd0, d_sen}, 8'h00);
    run_frame(4);
    chk("stall_1001", 8'(rx[0]), E_9_M);
    chk("stall_1001l", 8'(rx[1]), E_9_L);

    for (int n = 0; n < 400; n++) begin
      lv = ($urandom % 3) == 0;
      ld = 4'($urandom);
      repeat ($urandom_range(1, 5)) cyc();
      if (($urandom % 8) != 0) cen = ~cen;
      if (($urandom % 150) == 0) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
      end
    end
    lv = 1'b0;
    run_frame(3);
    repeat (4) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ttl_serializer_sync.md
Name: ttl_serializer_sync

Overview:
- Parallel-in, serial-out transmitter. It loads a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per cen period.
- Its outputs are shaped to feed a 74194-style universal shift register receiver in shift-right mode:
  - ser_out drives the receiver's Dsr input.
  - shift_en drives the receiver's S0 input (with S1 tied low).
- It is the sending end of the board-level serial links our sync TTL models rebuild. Like those models, it is fully synchronous to clk and uses cen edge detection.

Parameters:
- WIDTH, 4, data bits per frame; must be >= 2.
- MSB_FIRST, 1, 1 = load_data[WIDTH-1] is sent first; 0 = load_data[0] is sent first.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous reset, active-high.
- cen  in  1  shift clock, sampled in the clk domain. A rising edge is cen=1 with last_cen=0; a falling edge is cen=0 with last_cen=1.
- load_valid  in  1  word offered.
- load_data  in  WIDTH  word to send.
- load_ready  out  1  block can accept a word.
- ser_out  out  1  serial data to the receiver's Dsr.
- shift_en  out  1  high while a frame is on the line; drives the receiver's S0.
- busy  out  1  frame in progress (state != IDLE).
- frame_done  out  1  one-clk pulse at frame end.

Behaviour:
- Reset values (asynchronous):
  - state = IDLE, last_cen = 1, shift register = 0, bit counter = 0.
  - ser_out = 0, shift_en = 0, frame_done = 0, busy = 0, load_ready = 1.
- last_cen <= cen on every clk edge.
- FRAME_LEN = WIDTH, or WIDTH+1 when parity is enabled (see Optional Feature).
- Bit counter width is clog2(WIDTH+2).
- Data changes only on cen falling edges. The receiver samples on cen rising edges, so every bit is stable for the half-period before its sampling edge.
- IDLE:
  - load_ready = 1.
  - load_valid & load_ready: capture load_data, clear the counter, go to ARM. The handshake is not gated by cen.
  - load_ready = 0 from the clk after capture until the block returns to IDLE.
- ARM:
  - Wait for a cen falling edge.
  - On that edge: ser_out = first bit, shift_en = 1, go to SHIFT.
- SHIFT:
  - cen rising edge: counter += 1 (the receiver has taken one bit). If the counter now equals FRAME_LEN, go to TAIL.
  - cen falling edge: ser_out = next bit. Bit order follows MSB_FIRST; the shift register shifts toward the output end.
- TAIL:
  - On the next cen falling edge: shift_en = 0, ser_out = 0, frame_done = 1 for one clk, go to IDLE.
  - This keeps shift_en high through the last sampling edge and drops it before the receiver's next rising edge, so the receiver holds.
- A load accepted in the same clk as frame_done's IDLE entry is not possible. IDLE is entered on that clk and load_ready goes high from it, so back-to-back frames have at least one full cen period gap.
- cen held constant: no edges, so the state, counter, ser_out and shift_en all freeze. No timeout.
- Rising and falling edges are mutually exclusive in any single clk.
- rst mid-frame: all outputs return to reset values immediately, the frame is discarded, and no frame_done is produced.
- load_valid while busy: ignored. No capture, no error.

Optional Feature:
- Macro: TTL_SERIALIZER_PARITY_EN.
- Defined:
  - FRAME_LEN = WIDTH+1.
  - After the last data bit, one extra bit equal to the XOR of the captured word (even parity) is presented. It follows the same falling-edge-present / rising-edge-count rules.
  - Parity is computed at capture and held.
- Not defined: FRAME_LEN = WIDTH and no parity logic is synthesised.

Test Plan:
1. WIDTH=4, MSB_FIRST=1, cen period 8 clk. Load 4'b1011 → ser_out 1,0,1,1 on successive rising edges. shift_en is high for exactly 4 rising edges. A 74194-style receiver in shift-right mode then reads Q3..Q0 = 1,0,1,1. frame_done pulses once; load_ready returns to 1.
2. MSB_FIRST=0. Load 4'b1011 → ser_out sequence 1,1,0,1. The receiver holds its value after shift_en falls.
3. Hold load_valid high with load_data 4'hF during an active 4'h5 frame → the receiver gets only 4'h5. 4'hF is accepted only after IDLE is re-entered, and is sent as a second frame.
4. Assert rst after 2 rising edges of a frame → ser_out, shift_en and busy drop to 0 within the assertion cycle and frame_done stays 0. After release, load 4'hA → a clean 4-bit frame.
5. Load, then hold cen low for 100 clk → the block stays in ARM with shift_en=0. Resume cen toggling → the normal frame completes.
6. TTL_SERIALIZER_PARITY_EN defined, load 4'b1011 → 5 bits 1,0,1,1,1, with shift_en high for 5 rising edges. Load 4'b1001 → final bit 0.
